// File: rtl/ysyx_23060184_wb_arb.sv
// Writeback arbiter: round-robin over EXU/LSU writes plus RAW scoreboard.
// Optional WBARB_BYPASS_EN: hide busy for the register being written this cycle.
module ysyx_23060184_wb_arb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  mark_valid,
  input  logic [ADDR_WIDTH-1:0] mark_addr,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  commit_valid,
  input  logic [ADDR_WIDTH-1:0] qry_addr1,
  input  logic [ADDR_WIDTH-1:0] qry_addr2,
  output logic                  busy1,
  output logic                  busy2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // last = 1 means channel 1 won most recently
  logic                  last;
  logic                  gnt0;
  logic                  gnt1;
  logic                  acc;
  logic                  acc_wr;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_nxt;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt0 = last;
      gnt1 = ~last;
    end else begin
      gnt0 = req0_valid;
      gnt1 = req1_valid;
    end
  end

  assign req0_ready = rstn & gnt0;
  assign req1_ready = rstn & gnt1;
  assign acc        = req0_ready | req1_ready;
  assign acc_addr   = req1_ready ? req1_addr : req0_addr;
  assign acc_data   = req1_ready ? req1_data : req0_data;
  assign acc_wr     = acc && (acc_addr != '0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last     <= 1'b1;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (acc) last <= req1_ready;
      rf_wen <= acc_wr;
      if (acc_wr) begin
        rf_waddr <= acc_addr;
        rf_wdata <= acc_data;
      end
    end
  end

  assign commit_valid = rf_wen;

  // A new mark beats a same-edge clear: its producer is still outstanding
  always_comb begin
    busy_nxt = busy;
    if (rf_wen) busy_nxt[rf_waddr] = 1'b0;
    if (mark_valid && (mark_addr != '0)) busy_nxt[mark_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) busy <= '0;
    else       busy <= busy_nxt;
  end

`ifdef WBARB_BYPASS_EN
  logic byp1;
  logic byp2;

  assign byp1 = rf_wen && (rf_waddr == qry_addr1)
             && !(mark_valid && (mark_addr == qry_addr1));
  assign byp2 = rf_wen && (rf_waddr == qry_addr2)
             && !(mark_valid && (mark_addr == qry_addr2));
  assign busy1 = busy[qry_addr1] & ~byp1;
  assign busy2 = busy[qry_addr2] & ~byp2;
`else
  assign busy1 = busy[qry_addr1];
  assign busy2 = busy[qry_addr2];
`endif

endmodule

// File: tb/tb_ysyx_23060184_wb_arb.sv
// Bench for ysyx_23060184_wb_arb: directed plan cases then random traffic
// checked against a behavioural arbiter/scoreboard model.
module tb_ysyx_23060184_wb_arb;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0_valid, req0_ready;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req1_valid, req1_ready;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        mark_valid;
  logic [4:0]  mark_addr;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit_valid;
  logic [4:0]  qry_addr1, qry_addr2;
  logic        busy1, busy2;

  ysyx_23060184_wb_arb #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .mark_valid(mark_valid), .mark_addr(mark_addr),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .commit_valid(commit_valid),
    .qry_addr1(qry_addr1), .qry_addr2(qry_addr2),
    .busy1(busy1), .busy2(busy2)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // model state
  int          m_last;
  bit          m_busy[32];
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          g_win;

`ifdef WBARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_busy(input logic [4:0] q, input bit mv,
                                  input logic [4:0] ma);
    bit b;
    b = m_busy[q];
    if (BYP && m_wen && m_waddr == q && !(mv && ma == q)) b = 1'b0;
    return b;
  endfunction

  task automatic model_reset();
    m_last  = 1;
    m_wen   = 0;
    m_waddr = '0;
    m_wdata = '0;
    foreach (m_busy[i]) m_busy[i] = 0;
  endtask

  task automatic step(input bit r,
                      input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                      input bit mv, input logic [4:0] ma,
                      input logic [4:0] q1, input logic [4:0] q2);
    int          win;
    bit          ow;
    logic [4:0]  oa;
    logic [4:0]  wa;
    logic [31:0] wd;
    @(negedge clk);
    rstn = r;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    mark_valid = mv; mark_addr = ma;
    qry_addr1 = q1;  qry_addr2 = q2;
    #1;
    win = -1;
    if (r) begin
      if (v0 && v1) win = 1 - m_last;
      else if (v0)  win = 0;
      else if (v1)  win = 1;
    end
    g_win = win;
    chk("ready0", req0_ready, win == 0);
    chk("ready1", req1_ready, win == 1);
    chk("busy1", busy1, exp_busy(q1, mv, ma));
    chk("busy2", busy2, exp_busy(q2, mv, ma));
    chk("rf_wen", rf_wen, m_wen);
    chk("commit", commit_valid, m_wen);
    chk("rf_waddr", rf_waddr, m_waddr);
    chk("rf_wdata", rf_wdata, m_wdata);
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else begin
      ow = m_wen;
      oa = m_waddr;
      wa = (win == 1) ? a1 : a0;
      wd = (win == 1) ? d1 : d0;
      if (win >= 0) m_last = win;
      m_wen = (win >= 0) && (wa != 0);
      if (m_wen) begin
        m_waddr = wa;
        m_wdata = wd;
      end
      if (ow) m_busy[oa] = 0;
      if (mv && ma != 0) m_busy[ma] = 1;
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] q);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, q, 0);
  endtask

  bit          h0, h1;
  bit          v0, v1, mv, r;
  logic [4:0]  a0, a1, ma;
  logic [31:0] d0, d1;

  initial begin
    rstn = 0;
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    mark_valid = 0; mark_addr = 0;
    qry_addr1 = 0;  qry_addr2 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", rf_wen, 0);
    chk("rst_waddr", rf_waddr, 0);
    step(0, 1, 3, 1, 1, 4, 2, 0, 0, 0, 0);

    // single write on channel 0
    step(1, 1, 5, 32'h12345678, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_wen", rf_wen, 1);
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 32'h12345678);
    chk("t1_commit", commit_valid, 1);
    idle(0);
    chk("t1_wen_off", rf_wen, 0);

    // x0 write from channel 1 is accepted and dropped
    step(1, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    chk("t3_wen", rf_wen, 0);
    chk("t3_commit", commit_valid, 0);

    // contention alternates 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, i, 1, 2, i + 100, 0, 0, 0, 0);
      chk("t2_waddr", rf_waddr, (i % 2 == 0) ? 1 : 2);
    end

    // mark, then write clears
    step(1, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    chk("t4_busy_set", busy1, 1);
    step(1, 1, 7, 32'h77, 0, 0, 0, 0, 0, 7, 0);
    chk("t4_busy_wcyc", busy1, BYP ? 0 : 1);
    idle(7);
    chk("t4_busy_clr", busy1, 0);

    // set beats clear on the same register
    step(1, 1, 9, 32'h99, 0, 0, 0, 0, 0, 9, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    chk("t5_busy9", busy1, 1);

    // reset right after an accept
    step(1, 1, 3, 32'h33, 0, 0, 0, 0, 0, 9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    chk("t6_wen", rf_wen, 0);
    chk("t6_busy", busy1, 0);
    step(1, 1, 4, 32'h44, 1, 6, 32'h66, 0, 0, 0, 0);
    chk("t6_tie_waddr", rf_waddr, 4);

    // random traffic; a losing request holds its payload
    h0 = 0; h1 = 0;
    v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!h0) begin
        v0 = ($urandom_range(0, 3) != 0);
        a0 = 5'($urandom_range(0, 7));
        d0 = $urandom;
      end
      if (!h1) begin
        v1 = ($urandom_range(0, 2) != 0);
        a1 = 5'($urandom_range(0, 7));
        d1 = $urandom;
      end
      r  = ($urandom_range(0, 99) != 0);
      mv = ($urandom_range(0, 2) == 0);
      ma = 5'($urandom_range(0, 7));
      step(r, v0, a0, d0, v1, a1, d1, mv, ma,
           5'($urandom_range(0, 8)), 5'($urandom_range(0, 8)));
      h0 = r && v0 && (g_win != 0);
      h1 = r && v1 && (g_win != 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
